// File: rtl/hamming15_pkg.sv
// Shared geometry, types and the data-position map for the Hamming(15,11) code.
// Code position p (1..15) lives at codeword bit p-1.
package hamming15_pkg;

  localparam int CODE_W = 15;
  localparam int DATA_W = 11;
  localparam int SYN_W  = 4;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [DATA_W-1:0] data_t;

  // Parity position k doubles as the mask selecting the positions it covers.
  localparam int PARITY_POS [SYN_W]  = '{1, 2, 4, 8};
  localparam int DATA_POS   [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  function automatic data_t extract_data(input code_t code);
    data_t data;
    data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      data[i] = code[DATA_POS[i]-1];
    end
    return data;
  endfunction

endpackage

// File: rtl/hamming15_syndrome.sv
// Combinational Hamming(15,11) syndrome: the value is the position of a single
// flipped bit, or zero for a clean codeword.
module hamming15_syndrome
  import hamming15_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syndrome
);

  always_comb begin
    syndrome = '0;
    for (int k = 0; k < SYN_W; k++) begin
      for (int i = 0; i < CODE_W; i++) begin
        if (((i + 1) & PARITY_POS[k]) != 0) begin
          syndrome[k] = syndrome[k] ^ code[i];
        end
      end
    end
  end

endmodule

// File: rtl/hamming15_dec.sv
// Two-stage valid/ready Hamming(15,11) single-error-correcting decoder.
// Define HAMMING15_DEC_STATS_EN to build the saturating corrected-word counter.
module hamming15_dec
  import hamming15_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [SYN_W-1:0]  syndrome,
  output logic              corrected,
  input  logic              err_count_clr,
  output logic [15:0]       err_count
);

  logic [SYN_W-1:0]  syn_in;

  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [SYN_W-1:0]  s1_syn;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_data;
  logic [SYN_W-1:0]  s2_syn;
  logic              s2_corr;

  logic              s2_load;
  logic              s1_adv;
  logic [CODE_W-1:0] flip;
  logic [CODE_W-1:0] fixed_code;

  hamming15_syndrome u_syndrome (
    .code     (code_in),
    .syndrome (syn_in)
  );

  assign s2_load  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = !s1_valid || s1_adv;

  // Syndrome is the 1-based position of the bit to invert.
  always_comb begin
    flip = '0;
    if (s1_syn != '0) begin
      flip[s1_syn - 4'd1] = 1'b1;
    end
  end

  assign fixed_code = s1_code ^ flip;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= code_in;
        s1_syn  <= syn_in;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_syn   <= '0;
      s2_corr  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= extract_data(fixed_code);
        s2_syn  <= s1_syn;
        s2_corr <= (s1_syn != '0);
      end
    end
  end

  assign out_valid = s2_valid;
  assign data_out  = s2_data;
  assign syndrome  = s2_syn;
  assign corrected = s2_corr;

`ifdef HAMMING15_DEC_STATS_EN
  logic [15:0] err_cnt_q;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_count_clr) begin
      err_cnt_q <= '0;
    end else if (s2_valid && out_ready && s2_corr && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_err_count_clr;
  assign unused_err_count_clr = err_count_clr;
  assign err_count = '0;
`endif

endmodule
